cal_result_collector: RTL and testbench
=======================================

// Module: cal_result_collector
// PURPOSE
//  Downstream consumer of the field-sum calculator's 5-bit result stream (out/validout).
//  - Sums every GROUP consecutive valid samples into one group total.
//  - Buffers group totals in a DEPTH-entry first-word-fall-through FIFO.
//  - Delivers totals to the next stage over a valid/ready handshake and flags lost groups.
// PARAMETERS
//  GROUP  4  samples per group (2..16)
//  DEPTH  4  FIFO entries (power of 2, >=2)
//  ACC_W  8  group-sum width; must be >= 5+clog2(GROUP)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  in_data    in   5      sample (calculator out)
//  in_valid   in   1      sample valid (calculator validout); each high cycle = one sample
//  flush      in   1      push the current partial group now
//  o_data     out  ACC_W  head-entry group sum
//  o_cnt      out  CW     head-entry sample count, CW=clog2(GROUP+1)
//  o_valid    out  1      FIFO non-empty
//  o_ready    in   1      downstream accepts head when o_valid&o_ready
//  ovf        out  1      sticky: a group was dropped on a full FIFO
//  clr_ovf    in   1      synchronous clear of ovf
//  o_max      out  5      head-entry max sample (only with CAL_MAX_TRACK_EN)
// BEHAVIOUR
//  Reset (rst=0, async): acc=0, cnt=0, FSM=IDLE, FIFO empty; o_data=0, o_cnt=0, o_valid=0, ovf=0.
//  FSM:
//  - IDLE: no partial group.
//  - ACC: 1..GROUP-1 samples held.
//  - IDLE->ACC on in_valid (acc=in_data, cnt=1).
//  - ACC: in_valid adds zero-extended in_data to acc and increments cnt.
//  - Push when (a) the sample making cnt==GROUP arrives, or (b) flush is high with cnt>=1.
//  - Push writes {acc+sample, cnt+sample?1:0}; then acc=0, cnt=0, FSM->IDLE.
//  Boundary rules:
//  - flush in IDLE with in_valid=0: no-op, no push.
//  - flush in IDLE with in_valid=1: pushes a 1-sample group.
//  - in_valid and flush in the same cycle: the sample is included, then a single push.
//  - in_valid low mid-group: the partial group is held indefinitely, no timeout.
//  Latency: push at clock edge k -> o_valid=1 and head visible after edge k, if the FIFO was empty.
//  FIFO:
//  - Pop on o_valid&o_ready.
//  - Push while full and not popping: entry dropped, ovf<=1, accumulator still cleared.
//  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
//  - Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
//  - When empty: o_data, o_cnt and o_max read 0.
//  ovf: set has priority over a same-cycle clr_ovf.
//  Arithmetic: unsigned, no saturation; ACC_W rule guarantees no overflow (GROUP=4: max 124).
// CONFIGURATION
//  CAL_MAX_TRACK_EN:
//  - Defined: per-group running max of in_data, reset with the group, stored per FIFO entry and
//    driven on o_max. Max of a 1-sample group is that sample.
//  - Undefined: no o_max port, no max storage; all other behaviour identical.
// TESTING (GROUP=4, DEPTH=4, ACC_W=8)
//  1) Samples 1,2,3,4 on consecutive cycles, o_ready=1 -> one entry o_data=10, o_cnt=4,
//     o_valid high one cycle.
//  2) Samples 31,31 then flush -> o_data=62, o_cnt=2; flush again in IDLE -> no entry.
//  3) o_ready=0, 20 samples of 31 -> 4 entries of 124; 5th group dropped, ovf=1.
//     clr_ovf -> ovf=0. Drain: exactly 4 pops of 124.
//  4) FIFO full, o_ready=1 on the cycle the 4th sample of a new group arrives -> no drop,
//     ovf stays 0, occupancy stays 4.
//  5) rst low after 3 samples -> all outputs 0. Next samples 5,5,5,5 -> o_data=20, o_cnt=4.
//  6) With CAL_MAX_TRACK_EN: samples 3,17,9,2 -> o_data=31, o_max=17.
//     Flush after sample 7 alone -> o_max=7.

Source files
------------

// File: rtl/cal_result_collector.sv
// Groups the calculator result stream into sums and queues them in a small FWFT FIFO.
// Optional per-group max tracking is enabled by defining CAL_MAX_TRACK_EN.
module cal_result_collector #(
    parameter int GROUP = 4,
    parameter int DEPTH = 4,
    parameter int ACC_W = 8,
    localparam int CW = $clog2(GROUP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       in_data,
    input  logic             in_valid,
    input  logic             flush,
    output logic [ACC_W-1:0] o_data,
    output logic [CW-1:0]    o_cnt,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             ovf,
    input  logic             clr_ovf
`ifdef CAL_MAX_TRACK_EN
    ,
    output logic [4:0]       o_max
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACC} state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt, g_sum, smp;
    logic [CW-1:0]     cnt, cnt_nxt, g_cnt;
    logic              push, pop, full, wr, drop;

    logic [ACC_W-1:0]  mem_sum [DEPTH];
    logic [CW-1:0]     mem_cnt [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       occ;

    assign smp = {{(ACC_W-5){1'b0}}, in_data};

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        g_sum     = acc;
        g_cnt     = cnt;
        unique case (state)
            IDLE: begin
                g_sum = in_valid ? smp : '0;
                g_cnt = in_valid ? CW'(1) : '0;
            end
            ACC: begin
                g_sum = in_valid ? acc + smp : acc;
                g_cnt = in_valid ? cnt + CW'(1) : cnt;
            end
            default: ;
        endcase
        push = (in_valid && g_cnt == CW'(GROUP)) || (flush && g_cnt != '0);
        if (push) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else if (in_valid) begin
            state_nxt = ACC;
            acc_nxt   = g_sum;
            cnt_nxt   = g_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign o_valid = occ != '0;
    assign full    = occ == (AW+1)'(DEPTH);
    assign pop     = o_valid && o_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr      = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            unique case ({wr, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
            if (drop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_sum[wptr] <= g_sum;
            mem_cnt[wptr] <= g_cnt;
        end
    end

    assign o_data = o_valid ? mem_sum[rptr] : '0;
    assign o_cnt  = o_valid ? mem_cnt[rptr] : '0;

`ifdef CAL_MAX_TRACK_EN
    logic [4:0] mx, g_mx;
    logic [4:0] mem_max [DEPTH];

    always_comb begin
        g_mx = mx;
        if (in_valid && (state == IDLE || in_data > mx))
            g_mx = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mx <= '0;
        else if (push)
            mx <= '0;
        else if (in_valid)
            mx <= g_mx;
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem_max[wptr] <= g_mx;
    end

    assign o_max = o_valid ? mem_max[rptr] : '0;
`endif

endmodule

// File: tb/tb_cal_result_collector.sv
// Randomised and directed checks of cal_result_collector against a queue model.
// Build with CAL_MAX_TRACK_EN defined to also cover o_max.
module tb_cal_result_collector;

    localparam int GROUP = 4;
    localparam int DEPTH = 4;

    logic       clk = 0;
    logic       rst = 0;
    logic [4:0] in_data = 0;
    logic       in_valid = 0;
    logic       flush = 0;
    logic [7:0] o_data;
    logic [2:0] o_cnt;
    logic       o_valid;
    logic       o_ready = 0;
    logic       ovf;
    logic       clr_ovf = 0;
`ifdef CAL_MAX_TRACK_EN
    logic [4:0] o_max;
`endif

    int tests = 0;
    int fails = 0;

    cal_result_collector #(.GROUP(GROUP), .DEPTH(DEPTH), .ACC_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .flush(flush), .o_data(o_data), .o_cnt(o_cnt), .o_valid(o_valid),
        .o_ready(o_ready), .ovf(ovf), .clr_ovf(clr_ovf)
`ifdef CAL_MAX_TRACK_EN
        , .o_max(o_max)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int cnt;
        int mx;
    } ent_t;

    ent_t mq[$];
    int   part[$];
    bit   m_ovf;

    function automatic int e_sum();
        return mq.size() > 0 ? mq[0].sum : 0;
    endfunction
    function automatic int e_cnt();
        return mq.size() > 0 ? mq[0].cnt : 0;
    endfunction
    function automatic int e_max();
        return mq.size() > 0 ? mq[0].mx : 0;
    endfunction

    task automatic model_clear();
        mq.delete();
        part.delete();
        m_ovf = 0;
    endtask

    // One clock: drive inputs, advance the model, settle 1 unit past the edge.
    task automatic step(bit v, int d, bit f, bit r, bit c);
        bit   pop, full, pg;
        ent_t e;
        in_valid = v;
        in_data  = d[4:0];
        flush    = f;
        o_ready  = r;
        clr_ovf  = c;
        @(posedge clk);
        pop  = mq.size() > 0 && r;
        full = mq.size() == DEPTH;
        if (v)
            part.push_back(d);
        pg = part.size() == GROUP || (f && part.size() > 0);
        if (pop)
            void'(mq.pop_front());
        if (pg) begin
            e.sum = 0;
            e.mx  = 0;
            foreach (part[i]) begin
                e.sum += part[i];
                if (part[i] > e.mx)
                    e.mx = part[i];
            end
            e.cnt = part.size();
            part.delete();
        end
        if (pg && full && !pop)
            m_ovf = 1;
        else begin
            if (pg)
                mq.push_back(e);
            if (c)
                m_ovf = 0;
        end
        #1;
        in_valid = 0;
        flush    = 0;
        clr_ovf  = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        model_clear();
        #3;
        rst = 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        #2;
        tests++;
        if (o_valid !== 0 || o_data !== 0 || o_cnt !== 0 || ovf !== 0) begin
            fails++;
            $display("FAIL reset: valid=%0b data=%0d cnt=%0d ovf=%0b want all 0",
                     o_valid, o_data, o_cnt, ovf);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++)
            step(1, i, 0, 1, 0);
        tests++;
        if (o_valid !== 1 || o_data !== 8'd10 || o_cnt !== 3'd4) begin
            fails++;
            $display("FAIL basic_group: valid=%0b data=%0d cnt=%0d want 1/10/4",
                     o_valid, o_data, o_cnt);
        end
        step(0, 0, 0, 1, 0);
        tests++;
        if (o_valid !== 0 || o_data !== 0) begin
            fails++;
            $display("FAIL basic_pop: valid=%0b data=%0d want 0/0", o_valid, o_data);
        end
    endtask

    task automatic test_flush();
        step(1, 31, 0, 1, 0);
        step(1, 31, 0, 1, 0);
        tests++;
        if (o_valid !== 0) begin
            fails++;
            $display("FAIL flush_hold: valid=%0b want 0", o_valid);
        end
        step(0, 0, 1, 1, 0);
        tests++;
        if (o_valid !== 1 || o_data !== 8'd62 || o_cnt !== 3'd2) begin
            fails++;
            $display("FAIL flush_push: valid=%0b data=%0d cnt=%0d want 1/62/2",
                     o_valid, o_data, o_cnt);
        end
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        tests++;
        if (o_valid !== 0) begin
            fails++;
            $display("FAIL flush_idle: valid=%0b want 0", o_valid);
        end
        step(1, 9, 1, 1, 0);
        tests++;
        if (o_valid !== 1 || o_data !== 8'd9 || o_cnt !== 3'd1) begin
            fails++;
            $display("FAIL flush_same: valid=%0b data=%0d cnt=%0d want 1/9/1",
                     o_valid, o_data, o_cnt);
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_overflow();
        int pops;
        for (int i = 0; i < 19; i++)
            step(1, 31, 0, 0, 0);
        tests++;
        if (ovf !== 0) begin
            fails++;
            $display("FAIL ovf_early: ovf=%0b want 0", ovf);
        end
        step(1, 31, 0, 0, 0);
        tests++;
        if (ovf !== 1 || o_data !== 8'd124 || o_cnt !== 3'd4) begin
            fails++;
            $display("FAIL ovf_set: ovf=%0b data=%0d cnt=%0d want 1/124/4",
                     ovf, o_data, o_cnt);
        end
        step(0, 0, 0, 0, 1);
        tests++;
        if (ovf !== 0) begin
            fails++;
            $display("FAIL ovf_clr: ovf=%0b want 0", ovf);
        end
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid === 1 && o_data === 8'd124)
                pops++;
            step(0, 0, 0, 1, 0);
        end
        tests++;
        if (pops != 4 || o_valid !== 0) begin
            fails++;
            $display("FAIL ovf_drain: pops=%0d valid=%0b want 4/0", pops, o_valid);
        end
    endtask

    task automatic test_full_pop();
        int pops;
        for (int i = 0; i < 19; i++)
            step(1, i % 32, 0, 0, 0);
        step(1, 7, 0, 1, 0);
        tests++;
        if (ovf !== 0 || o_valid !== 1 || o_data !== 8'(e_sum())) begin
            fails++;
            $display("FAIL full_pop: ovf=%0b valid=%0b data=%0d want 0/1/%0d",
                     ovf, o_valid, o_data, e_sum());
        end
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid === 1)
                pops++;
            step(0, 0, 0, 1, 0);
        end
        tests++;
        if (pops != 4) begin
            fails++;
            $display("FAIL full_occ: pops=%0d want 4", pops);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 3, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        rst = 0;
        model_clear();
        #2;
        tests++;
        if (o_valid !== 0 || o_data !== 0 || o_cnt !== 0 || ovf !== 0) begin
            fails++;
            $display("FAIL reset_mid: valid=%0b data=%0d cnt=%0d ovf=%0b want 0",
                     o_valid, o_data, o_cnt, ovf);
        end
        rst = 1;
        for (int i = 0; i < 4; i++)
            step(1, 5, 0, 0, 0);
        tests++;
        if (o_valid !== 1 || o_data !== 8'd20 || o_cnt !== 3'd4) begin
            fails++;
            $display("FAIL reset_after: valid=%0b data=%0d cnt=%0d want 1/20/4",
                     o_valid, o_data, o_cnt);
        end
        step(0, 0, 0, 1, 0);
    endtask

`ifdef CAL_MAX_TRACK_EN
    task automatic test_max();
        step(1, 3, 0, 0, 0);
        step(1, 17, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        tests++;
        if (o_data !== 8'd31 || o_max !== 5'd17) begin
            fails++;
            $display("FAIL max_group: data=%0d max=%0d want 31/17", o_data, o_max);
        end
        step(0, 0, 0, 1, 0);
        step(1, 7, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        tests++;
        if (o_cnt !== 3'd1 || o_max !== 5'd7) begin
            fails++;
            $display("FAIL max_single: cnt=%0d max=%0d want 1/7", o_cnt, o_max);
        end
        step(0, 0, 0, 1, 0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(9, 0) < 7, int'($urandom_range(31, 0)),
                 $urandom_range(9, 0) < 2, $urandom_range(1, 0) == 1,
                 $urandom_range(9, 0) == 0);
            tests++;
            if (o_valid !== (mq.size() > 0) || o_data !== 8'(e_sum()) ||
                o_cnt !== 3'(e_cnt()) || ovf !== m_ovf) begin
                fails++;
                $display("FAIL rand[%0d]: v=%0b d=%0d c=%0d ovf=%0b want %0b/%0d/%0d/%0b",
                         i, o_valid, o_data, o_cnt, ovf,
                         mq.size() > 0, e_sum(), e_cnt(), m_ovf);
            end
`ifdef CAL_MAX_TRACK_EN
            tests++;
            if (o_max !== 5'(e_max())) begin
                fails++;
                $display("FAIL rand_max[%0d]: max=%0d want %0d", i, o_max, e_max());
            end
`endif
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_flush();
        test_overflow();
        test_full_pop();
        test_reset_mid();
`ifdef CAL_MAX_TRACK_EN
        test_max();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
